// File: rtl/id_stage_reg.sv
// id_stage_reg: MIPS integer decode stage with a registered ID/EX slot.
//   - Decodes the IF/ID instruction, reads the regfile combinationally and
//     resolves operands through FWD_N prioritised bypass channels
//     (channel 0 = youngest, wins).
//   - Stalls on a load-use hazard (winning bypass match still pending).
//   - Holds one decoded instruction in an output slot with valid/ready
//     handshake; flush kills both the slot and the incoming instruction.
// Ports:
//   clk, rst (sync, active-high)
//   in_valid_i / in_ready_o, pc_i, inst_i      : upstream handshake + fetch data
//   reg{1,2}_read_o, reg{1,2}_addr_o, reg{1,2}_data_i : regfile read side
//   fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_pend_i     : bypass channels (packed, ch0 in LSBs)
//   flush_i                                      : pipeline flush
//   out_valid_o / out_ready_i, aluop_o, alusel_o, reg1_o, reg2_o,
//   wd_o, wreg_o, pc_o, inst_invalid_o           : ID/EX slot
module id_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int FWD_N   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [31:0]                pc_i,
  input  logic [31:0]                inst_i,
  output logic                       reg1_read_o,
  output logic                       reg2_read_o,
  output logic [RADDR_W-1:0]         reg1_addr_o,
  output logic [RADDR_W-1:0]         reg2_addr_o,
  input  logic [DATA_W-1:0]          reg1_data_i,
  input  logic [DATA_W-1:0]          reg2_data_i,
  input  logic [FWD_N-1:0]           fwd_wreg_i,
  input  logic [FWD_N*RADDR_W-1:0]   fwd_wd_i,
  input  logic [FWD_N*DATA_W-1:0]    fwd_wdata_i,
  input  logic [FWD_N-1:0]           fwd_pend_i,
  input  logic                       flush_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [7:0]                 aluop_o,
  output logic [2:0]                 alusel_o,
  output logic [DATA_W-1:0]          reg1_o,
  output logic [DATA_W-1:0]          reg2_o,
  output logic [RADDR_W-1:0]         wd_o,
  output logic                       wreg_o,
  output logic [31:0]                pc_o,
  output logic                       inst_invalid_o
);
  // opcodes / function codes
  localparam logic [5:0] OP_SPECIAL = 6'b000000, OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_XORI = 6'b001110, OP_LUI = 6'b001111;
  localparam logic [5:0] OP_SLTI = 6'b001010, OP_SLTIU = 6'b001011, OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_PREF = 6'b110011;
  localparam logic [5:0] FN_AND = 6'b100100, FN_OR = 6'b100101, FN_XOR = 6'b100110, FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLLV = 6'b000100, FN_SRLV = 6'b000110, FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_SLL = 6'b000000, FN_SRL = 6'b000010, FN_SRA = 6'b000011;
  localparam logic [5:0] FN_MOVZ = 6'b001010, FN_MOVN = 6'b001011;
  localparam logic [5:0] FN_MFHI = 6'b010000, FN_MTHI = 6'b010001, FN_MFLO = 6'b010010, FN_MTLO = 6'b010011;
  localparam logic [5:0] FN_SLT = 6'b101010, FN_SLTU = 6'b101011, FN_ADD = 6'b100000, FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB = 6'b100010, FN_SUBU = 6'b100011, FN_MULT = 6'b011000, FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_CLZ = 6'b100000, FN_CLO = 6'b100001, FN_MUL = 6'b000010;
  // ALU operation codes
  localparam logic [7:0] EXE_NOP_OP = 8'h00, EXE_AND_OP = 8'h24, EXE_OR_OP = 8'h25, EXE_XOR_OP = 8'h26;
  localparam logic [7:0] EXE_NOR_OP = 8'h27, EXE_SLL_OP = 8'h7C, EXE_SLLV_OP = 8'h04, EXE_SRL_OP = 8'h02;
  localparam logic [7:0] EXE_SRLV_OP = 8'h06, EXE_SRA_OP = 8'h03, EXE_SRAV_OP = 8'h07;
  localparam logic [7:0] EXE_MOVZ_OP = 8'h0A, EXE_MOVN_OP = 8'h0B, EXE_MFHI_OP = 8'h10, EXE_MTHI_OP = 8'h11;
  localparam logic [7:0] EXE_MFLO_OP = 8'h12, EXE_MTLO_OP = 8'h13, EXE_SLT_OP = 8'h2A, EXE_SLTU_OP = 8'h2B;
  localparam logic [7:0] EXE_ADD_OP = 8'h20, EXE_ADDU_OP = 8'h21, EXE_SUB_OP = 8'h22, EXE_SUBU_OP = 8'h23;
  localparam logic [7:0] EXE_MULT_OP = 8'h18, EXE_MULTU_OP = 8'h19, EXE_CLZ_OP = 8'hB0, EXE_CLO_OP = 8'hB1;
  localparam logic [7:0] EXE_MUL_OP = 8'hA9;
  // ALU result selectors
  localparam logic [2:0] EXE_RES_NOP = 3'd0, EXE_RES_LOGIC = 3'd1, EXE_RES_SHIFT = 3'd2;
  localparam logic [2:0] EXE_RES_MOVE = 3'd3, EXE_RES_ARITH = 3'd4, EXE_RES_MUL = 3'd5;

  logic [5:0]         w_op, w_fn;
  logic [4:0]         w_sa;
  logic [RADDR_W-1:0] w_rs, w_rt;
  logic [7:0]         w_aluop;
  logic [2:0]         w_alusel;
  logic               w_wreg, w_inval, w_movn, w_movz, w_rd1, w_rd2;
  logic [RADDR_W-1:0] w_wd;
  logic [31:0]        w_imm;
  logic [DATA_W:0]    w_res1, w_res2;  // {pending, data}
  logic [DATA_W-1:0]  w_op1, w_op2;
  logic               w_hazard, w_slot_free, w_accept, w_wreg_fin;

  assign w_op = inst_i[31:26];
  assign w_fn = inst_i[5:0];
  assign w_sa = inst_i[10:6];
  assign w_rs = RADDR_W'(inst_i[25:21]);
  assign w_rt = RADDR_W'(inst_i[20:16]);

  always_comb begin
    w_aluop = EXE_NOP_OP; w_alusel = EXE_RES_NOP; w_wreg = 1'b0; w_inval = 1'b1;
    w_movn = 1'b0; w_movz = 1'b0; w_rd1 = 1'b0; w_rd2 = 1'b0; w_imm = 32'h0;
    w_wd = RADDR_W'(inst_i[15:11]);
    case (w_op)
      OP_SPECIAL: begin
        if (w_sa == 5'd0) begin
          w_inval = 1'b0; w_rd1 = 1'b1; w_rd2 = 1'b1; w_wreg = 1'b1;
          case (w_fn)
            FN_AND:   begin w_aluop = EXE_AND_OP;  w_alusel = EXE_RES_LOGIC; end
            FN_OR:    begin w_aluop = EXE_OR_OP;   w_alusel = EXE_RES_LOGIC; end
            FN_XOR:   begin w_aluop = EXE_XOR_OP;  w_alusel = EXE_RES_LOGIC; end
            FN_NOR:   begin w_aluop = EXE_NOR_OP;  w_alusel = EXE_RES_LOGIC; end
            FN_SLLV:  begin w_aluop = EXE_SLLV_OP; w_alusel = EXE_RES_SHIFT; end
            FN_SRLV:  begin w_aluop = EXE_SRLV_OP; w_alusel = EXE_RES_SHIFT; end
            FN_SRAV:  begin w_aluop = EXE_SRAV_OP; w_alusel = EXE_RES_SHIFT; end
            FN_MOVZ:  begin w_aluop = EXE_MOVZ_OP; w_alusel = EXE_RES_MOVE; w_movz = 1'b1; end
            FN_MOVN:  begin w_aluop = EXE_MOVN_OP; w_alusel = EXE_RES_MOVE; w_movn = 1'b1; end
            FN_MFHI:  begin w_aluop = EXE_MFHI_OP; w_alusel = EXE_RES_MOVE; w_rd1 = 1'b0; w_rd2 = 1'b0; end
            FN_MFLO:  begin w_aluop = EXE_MFLO_OP; w_alusel = EXE_RES_MOVE; w_rd1 = 1'b0; w_rd2 = 1'b0; end
            FN_MTHI:  begin w_aluop = EXE_MTHI_OP; w_wreg = 1'b0; w_rd2 = 1'b0; end
            FN_MTLO:  begin w_aluop = EXE_MTLO_OP; w_wreg = 1'b0; w_rd2 = 1'b0; end
            FN_SLT:   begin w_aluop = EXE_SLT_OP;  w_alusel = EXE_RES_ARITH; end
            FN_SLTU:  begin w_aluop = EXE_SLTU_OP; w_alusel = EXE_RES_ARITH; end
            FN_ADD:   begin w_aluop = EXE_ADD_OP;  w_alusel = EXE_RES_ARITH; end
            FN_ADDU:  begin w_aluop = EXE_ADDU_OP; w_alusel = EXE_RES_ARITH; end
            FN_SUB:   begin w_aluop = EXE_SUB_OP;  w_alusel = EXE_RES_ARITH; end
            FN_SUBU:  begin w_aluop = EXE_SUBU_OP; w_alusel = EXE_RES_ARITH; end
            FN_MULT:  begin w_aluop = EXE_MULT_OP;  w_wreg = 1'b0; end
            FN_MULTU: begin w_aluop = EXE_MULTU_OP; w_wreg = 1'b0; end
            default:  begin w_inval = 1'b1; w_rd1 = 1'b0; w_rd2 = 1'b0; w_wreg = 1'b0; end
          endcase
        end
        // shift by immediate: shamt travels as operand 1
        if (inst_i[25:21] == 5'd0 && (w_fn == FN_SLL || w_fn == FN_SRL || w_fn == FN_SRA)) begin
          w_inval = 1'b0; w_wreg = 1'b1; w_rd1 = 1'b0; w_rd2 = 1'b1;
          w_alusel = EXE_RES_SHIFT; w_imm = {27'h0, w_sa};
          w_aluop = (w_fn == FN_SLL) ? EXE_SLL_OP : (w_fn == FN_SRL) ? EXE_SRL_OP : EXE_SRA_OP;
        end
      end
      OP_SPECIAL2: begin
        w_inval = 1'b0; w_wreg = 1'b1; w_rd1 = 1'b1;
        case (w_fn)
          FN_CLZ:  begin w_aluop = EXE_CLZ_OP; w_alusel = EXE_RES_ARITH; end
          FN_CLO:  begin w_aluop = EXE_CLO_OP; w_alusel = EXE_RES_ARITH; end
          FN_MUL:  begin w_aluop = EXE_MUL_OP; w_alusel = EXE_RES_MUL; w_rd2 = 1'b1; end
          default: begin w_inval = 1'b1; w_wreg = 1'b0; w_rd1 = 1'b0; end
        endcase
      end
      OP_ORI, OP_ANDI, OP_XORI, OP_LUI, OP_SLTI, OP_SLTIU, OP_ADDI, OP_ADDIU: begin
        w_inval = 1'b0; w_wreg = 1'b1; w_rd1 = 1'b1; w_wd = w_rt;
        w_imm = {16'h0, inst_i[15:0]};
        w_alusel = EXE_RES_ARITH;
        case (w_op)
          OP_ORI:   begin w_aluop = EXE_OR_OP;  w_alusel = EXE_RES_LOGIC; end
          OP_ANDI:  begin w_aluop = EXE_AND_OP; w_alusel = EXE_RES_LOGIC; end
          OP_XORI:  begin w_aluop = EXE_XOR_OP; w_alusel = EXE_RES_LOGIC; end
          OP_LUI:   begin w_aluop = EXE_OR_OP;  w_alusel = EXE_RES_LOGIC; w_imm = {inst_i[15:0], 16'h0}; end
          OP_SLTI:  begin w_aluop = EXE_SLT_OP;  w_imm = {{16{inst_i[15]}}, inst_i[15:0]}; end
          OP_SLTIU: begin w_aluop = EXE_SLTU_OP; w_imm = {{16{inst_i[15]}}, inst_i[15:0]}; end
          OP_ADDI:  begin w_aluop = EXE_ADD_OP;  w_imm = {{16{inst_i[15]}}, inst_i[15:0]}; end
          default:  begin w_aluop = EXE_ADDU_OP; w_imm = {{16{inst_i[15]}}, inst_i[15:0]}; end
        endcase
      end
      OP_PREF: w_inval = 1'b0;
      default: ;
    endcase
  end

  // Highest index first so the lowest matching channel overwrites last and wins.
  function automatic logic [DATA_W:0] resolve(input logic [RADDR_W-1:0] a, input logic [DATA_W-1:0] rf);
    logic [DATA_W:0] r;
    r = {1'b0, rf};
    for (int k = FWD_N - 1; k >= 0; k--)
      if (fwd_wreg_i[k] && fwd_wd_i[k*RADDR_W +: RADDR_W] == a)
        r = {fwd_pend_i[k], fwd_wdata_i[k*DATA_W +: DATA_W]};
    if (a == '0) r = '0;
    return r;
  endfunction

  assign w_res1 = resolve(w_rs, reg1_data_i);
  assign w_res2 = resolve(w_rt, reg2_data_i);
  assign w_op1  = w_rd1 ? w_res1[DATA_W-1:0] : DATA_W'(w_imm);
  assign w_op2  = w_rd2 ? w_res2[DATA_W-1:0] : DATA_W'(w_imm);
  // conditional moves decide write-back on the forwarded rt value
  assign w_wreg_fin = w_movn ? (w_op2 != '0) : w_movz ? (w_op2 == '0) : w_wreg;

  assign w_hazard    = in_valid_i & ((w_rd1 & w_res1[DATA_W]) | (w_rd2 & w_res2[DATA_W]));
  assign w_slot_free = ~out_valid_o | out_ready_i;
  assign in_ready_o  = w_slot_free & ~w_hazard & ~flush_i;
  assign w_accept    = in_valid_i & in_ready_o;

  assign reg1_read_o = w_rd1;
  assign reg2_read_o = w_rd2;
  assign reg1_addr_o = w_rs;
  assign reg2_addr_o = w_rt;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_o <= 1'b0; aluop_o <= EXE_NOP_OP; alusel_o <= EXE_RES_NOP;
      reg1_o <= '0; reg2_o <= '0; wd_o <= '0; wreg_o <= 1'b0; pc_o <= '0; inst_invalid_o <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (w_accept) begin
      out_valid_o    <= 1'b1;
      aluop_o        <= w_aluop;
      alusel_o       <= w_alusel;
      reg1_o         <= w_op1;
      reg2_o         <= w_op2;
      wd_o           <= w_wd;
      wreg_o         <= w_wreg_fin & ~w_inval;
      pc_o           <= pc_i;
      inst_invalid_o <= w_inval;
    end else if (w_slot_free) begin
      out_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_id_stage_reg.sv
module tb_id_stage_reg;
  localparam int DW = 32, AW = 5, FN = 2;
  localparam logic [7:0] OP_NOP = 8'h00, OP_OR = 8'h25, OP_ADD = 8'h20, OP_MOVZ = 8'h0A, OP_SLL = 8'h7C;
  localparam logic [2:0] S_NOP = 3'd0, S_LOGIC = 3'd1, S_SHIFT = 3'd2, S_MOVE = 3'd3, S_ARITH = 3'd4;

  logic clk = 1'b0, rst;
  logic in_valid_i, in_ready_o, reg1_read_o, reg2_read_o, flush_i, out_valid_o, out_ready_i;
  logic [31:0] pc_i, inst_i, pc_o;
  logic [AW-1:0] reg1_addr_o, reg2_addr_o, wd_o;
  logic [DW-1:0] reg1_data_i, reg2_data_i, reg1_o, reg2_o;
  logic [FN-1:0] fwd_wreg_i, fwd_pend_i;
  logic [FN*AW-1:0] fwd_wd_i;
  logic [FN*DW-1:0] fwd_wdata_i;
  logic [7:0] aluop_o;
  logic [2:0] alusel_o;
  logic wreg_o, inst_invalid_o;

  id_stage_reg #(.DATA_W(DW), .RADDR_W(AW), .FWD_N(FN)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .pc_i(pc_i), .inst_i(inst_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o), .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i), .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i),
    .fwd_wdata_i(fwd_wdata_i), .fwd_pend_i(fwd_pend_i), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o), .inst_invalid_o(inst_invalid_o));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] aluop; logic [2:0] alusel; logic [31:0] r1, r2;
    logic [4:0] wd; logic wreg; logic [31:0] pc; logic inv;
  } exp_t;

  exp_t exp_q[$];
  exp_t last;
  int n_pass = 0, n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [2:0] s, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [4:0] wd, input logic wr, input logic [31:0] pc, input logic inv);
    exp_t e;
    e.aluop = a; e.alusel = s; e.r1 = r1; e.r2 = r2; e.wd = wd; e.wreg = wr; e.pc = pc; e.inv = inv;
    exp_q.push_back(e);
  endtask

  task automatic chk_fields(input string t, input exp_t e);
    chk({t, ".valid"}, 32'(out_valid_o), 32'd1);
    chk({t, ".aluop"}, 32'(aluop_o), 32'(e.aluop));
    chk({t, ".alusel"}, 32'(alusel_o), 32'(e.alusel));
    chk({t, ".reg1"}, reg1_o, e.r1);
    chk({t, ".reg2"}, reg2_o, e.r2);
    chk({t, ".wd"}, 32'(wd_o), 32'(e.wd));
    chk({t, ".wreg"}, 32'(wreg_o), 32'(e.wreg));
    chk({t, ".pc"}, pc_o, e.pc);
    chk({t, ".inv"}, 32'(inst_invalid_o), 32'(e.inv));
  endtask

  // pop the oldest expected slot contents when the DUT presents a slot
  task automatic pop_chk(input string t);
    chk({t, ".valid"}, 32'(out_valid_o), 32'd1);
    if (exp_q.size() > 0) begin
      last = exp_q.pop_front();
      chk_fields(t, last);
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, ".valid"}, 32'(out_valid_o), 32'd0);
    chk({t, ".aluop"}, 32'(aluop_o), 32'(OP_NOP));
    chk({t, ".alusel"}, 32'(alusel_o), 32'(S_NOP));
    chk({t, ".reg1"}, reg1_o, 32'd0);
    chk({t, ".reg2"}, reg2_o, 32'd0);
    chk({t, ".wd"}, 32'(wd_o), 32'd0);
    chk({t, ".wreg"}, 32'(wreg_o), 32'd0);
    chk({t, ".pc"}, pc_o, 32'd0);
    chk({t, ".inv"}, 32'(inst_invalid_o), 32'd0);
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    in_valid_i = 1'b1; inst_i = inst; pc_i = pc;
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
    fwd_wreg_i = '0; fwd_pend_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0;
    reg1_data_i = 32'hDEAD; reg2_data_i = 32'hBEEF;
    drive(32'h34011234, 32'h100);   // valid input under reset must not load
    step(); step();
    chk_reset("reset");

    // ORI r1,r0,0x1234 ; r0 read data is junk but must resolve to 0
    rst = 1'b0; settle();
    chk("ori.in_ready", 32'(in_ready_o), 32'd1);
    chk("ori.addr1", 32'(reg1_addr_o), 32'd0);
    chk("ori.addr2", 32'(reg2_addr_o), 32'd1);
    chk("ori.read1", 32'(reg1_read_o), 32'd1);
    chk("ori.read2", 32'(reg2_read_o), 32'd0);
    push(OP_OR, S_LOGIC, 32'h0, 32'h1234, 5'd1, 1'b1, 32'h100, 1'b0);
    step(); pop_chk("ori");

    // backpressure: slot holds ORI for 3 cycles
    out_ready_i = 1'b0; drive(32'h00221820, 32'h104); reg1_data_i = 32'd11; reg2_data_i = 32'd22;
    for (int i = 0; i < 3; i++) begin
      settle(); chk("bp.in_ready", 32'(in_ready_o), 32'd0);
      step(); chk_fields("bp.hold", last);
    end
    out_ready_i = 1'b1; settle();
    chk("bp.release", 32'(in_ready_o), 32'd1);
    push(OP_ADD, S_ARITH, 32'd11, 32'd22, 5'd3, 1'b1, 32'h104, 1'b0);
    step(); pop_chk("bp.add");

    // forwarding priority: ch0 and ch1 both target r1, r2 from regfile
    drive(32'h00221820, 32'h108); reg1_data_i = 32'h77; reg2_data_i = 32'd9;
    fwd_wreg_i = 2'b11; fwd_wd_i = {5'd1, 5'd1}; fwd_wdata_i = {32'd7, 32'd5};
    settle(); chk("fwd.in_ready", 32'(in_ready_o), 32'd1);
    push(OP_ADD, S_ARITH, 32'd5, 32'd9, 5'd3, 1'b1, 32'h108, 1'b0);
    step(); pop_chk("fwd.ch0");
    drive(32'h00221820, 32'h10C); fwd_wd_i = {5'd1, 5'd0};
    push(OP_ADD, S_ARITH, 32'd7, 32'd9, 5'd3, 1'b1, 32'h10C, 1'b0);
    step(); pop_chk("fwd.ch1");

    // load-use stall on r2 for 2 cycles, then accept with forwarded data
    drive(32'h00221820, 32'h110); reg1_data_i = 32'h31;
    fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd2}; fwd_wdata_i = {32'd0, 32'h42}; fwd_pend_i = 2'b01;
    for (int i = 0; i < 2; i++) begin
      settle(); chk("stall.in_ready", 32'(in_ready_o), 32'd0);
      step(); chk("stall.valid", 32'(out_valid_o), 32'd0);
    end
    fwd_pend_i = 2'b00; settle();
    chk("stall.release", 32'(in_ready_o), 32'd1);
    push(OP_ADD, S_ARITH, 32'h31, 32'h42, 5'd3, 1'b1, 32'h110, 1'b0);
    step(); pop_chk("stall.add");

    // pending ch1 shadowed by non-pending ch0 must not stall
    drive(32'h00221820, 32'h114);
    fwd_wreg_i = 2'b11; fwd_wd_i = {5'd2, 5'd2}; fwd_wdata_i = {32'h60, 32'h50}; fwd_pend_i = 2'b10;
    settle(); chk("shadow.in_ready", 32'(in_ready_o), 32'd1);
    push(OP_ADD, S_ARITH, 32'h31, 32'h50, 5'd3, 1'b1, 32'h114, 1'b0);
    step(); pop_chk("shadow");

    // MOVZ r4,r1,r2 with forwarded rt
    drive(32'h0022200A, 32'h118); fwd_wreg_i = 2'b01; fwd_pend_i = 2'b00;
    fwd_wd_i = {5'd0, 5'd2}; fwd_wdata_i = {32'd0, 32'd0};
    push(OP_MOVZ, S_MOVE, 32'h31, 32'd0, 5'd4, 1'b1, 32'h118, 1'b0);
    step(); pop_chk("movz.zero");
    drive(32'h0022200A, 32'h11C); fwd_wdata_i = {32'd0, 32'd3};
    push(OP_MOVZ, S_MOVE, 32'h31, 32'd3, 5'd4, 1'b0, 32'h11C, 1'b0);
    step(); pop_chk("movz.nz");

    // SLL r5,r2,3 / LUI r3,0xABCD / ADDI r4,r0,-1
    fwd_wreg_i = 2'b00; reg2_data_i = 32'h0F;
    drive(32'h000228C0, 32'h120); settle();
    chk("sll.read1", 32'(reg1_read_o), 32'd0);
    chk("sll.read2", 32'(reg2_read_o), 32'd1);
    push(OP_SLL, S_SHIFT, 32'd3, 32'h0F, 5'd5, 1'b1, 32'h120, 1'b0);
    step(); pop_chk("sll");
    drive(32'h3C03ABCD, 32'h124);
    push(OP_OR, S_LOGIC, 32'd0, 32'hABCD0000, 5'd3, 1'b1, 32'h124, 1'b0);
    step(); pop_chk("lui");
    drive(32'h2004FFFF, 32'h128);
    push(OP_ADD, S_ARITH, 32'd0, 32'hFFFFFFFF, 5'd4, 1'b1, 32'h128, 1'b0);
    step(); pop_chk("addi");

    // flush with an accept request: nothing accepted, slot empties
    drive(32'h34011234, 32'h200); flush_i = 1'b1; settle();
    chk("flush.in_ready", 32'(in_ready_o), 32'd0);
    step(); chk("flush.valid", 32'(out_valid_o), 32'd0);
    flush_i = 1'b0; settle();
    chk("flush.after", 32'(in_ready_o), 32'd1);
    push(OP_OR, S_LOGIC, 32'h0, 32'h1234, 5'd1, 1'b1, 32'h200, 1'b0);
    step(); pop_chk("flush.ori");

    // invalid instruction
    drive(32'hFC000000, 32'h300);
    push(OP_NOP, S_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 32'h300, 1'b1);
    step(); pop_chk("invalid");

    // reset while stalled and backpressured
    out_ready_i = 1'b0; drive(32'h00221820, 32'h304);
    fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd2}; fwd_wdata_i = {32'd0, 32'h99}; fwd_pend_i = 2'b01;
    settle(); chk("rstall.in_ready", 32'(in_ready_o), 32'd0);
    step(); chk_fields("rstall.hold", last);
    rst = 1'b1; step(); chk_reset("rstall");
    rst = 1'b0; fwd_pend_i = 2'b00; out_ready_i = 1'b1; settle();
    chk("rstall.release", 32'(in_ready_o), 32'd1);
    push(OP_ADD, S_ARITH, 32'h31, 32'h99, 5'd3, 1'b1, 32'h304, 1'b0);
    step(); pop_chk("rstall.add");

    // empty input leaves a bubble
    in_valid_i = 1'b0; step();
    chk("bubble.valid", 32'(out_valid_o), 32'd0);
    chk("sb.left", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/id_stage_reg.md
# id_stage_reg

Parametrised successor to the combinational decode stage. It holds the same MIPS integer decode but adds:
- a registered ID/EX output slot with valid/ready handshake;
- `FWD_N` prioritised bypass channels;
- load-use hazard stalling;
- pipeline flush.

It sits between the IF/ID register and the EX stage, and on the read side it connects to the regfile.

## Interface
Parameters:
- `DATA_W`, 32: register/operand width.
- `RADDR_W`, 5: register address width.
- `FWD_N`, 2: number of bypass channels. Channel 0 is the youngest and has the highest priority.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid_i` in 1: `pc_i`/`inst_i` hold a valid instruction.
- `in_ready_o` out 1: instruction is accepted this cycle.
- `pc_i` in 32, `inst_i` in 32: fetched PC and instruction.
- `reg1_read_o`, `reg2_read_o` out 1: regfile read enables (combinational).
- `reg1_addr_o`, `reg2_addr_o` out `RADDR_W`: regfile read addresses, always `inst_i[25:21]` / `inst_i[20:16]`.
- `reg1_data_i`, `reg2_data_i` in `DATA_W`: regfile read data, combinational with respect to the addresses.
- `fwd_wreg_i` in `FWD_N`: channel k will write a register.
- `fwd_wd_i` in `FWD_N*RADDR_W`: channel k destination.
- `fwd_wdata_i` in `FWD_N*DATA_W`: channel k data.
- `fwd_pend_i` in `FWD_N`: channel k data is not yet available (load in flight).
- `flush_i` in 1: kill the instruction held in the slot and the one being accepted.
- `out_valid_o` out 1: slot holds a valid decoded instruction.
- `out_ready_i` in 1: EX consumes the slot.
- `aluop_o` out 8, `alusel_o` out 3: codes from `defines.v`.
- `reg1_o`, `reg2_o` out `DATA_W`: operands.
- `wd_o` out `RADDR_W`, `wreg_o` out 1: write-back destination and enable.
- `pc_o` out 32: PC of the slot instruction.
- `inst_invalid_o` out 1: slot instruction is not decodable.

## Operation
- **Decode set:** identical to the current decode stage. Covers SPECIAL logic/shift-variable/move/HI-LO/arith/mult, SPECIAL2 CLZ/CLO/MUL, ORI/ANDI/XORI/LUI/SLTI/SLTIU/ADDI/ADDIU/PREF, and SLL/SRL/SRA immediate.
- **Immediates:** zero-extended for logic immediates. Sign-extended for SLTI/SLTIU/ADDI/ADDIU. LUI places the immediate in `[31:16]`.
- **Operand selection:** an operand with its read enable deasserted takes `imm`, zero-extended to `DATA_W`.
- **Operand resolution, per source with read enable = 1, in this order:**
  - address 0 gives 0;
  - otherwise the lowest-index channel k with `fwd_wreg_i[k]` set and `fwd_wd_i[k]` equal to the address gives `fwd_wdata_i[k]`;
  - otherwise regfile data.
- **Hazard:** hazard = `in_valid_i` and some enabled, non-zero source whose winning matching channel has `fwd_pend_i` set.
  - A pending entry in a lower-priority channel that is shadowed by a non-pending higher-priority match does not stall.
- **MOVN/MOVZ:** `wreg` is computed from the resolved `reg2` after forwarding. MOVN writes when `reg2` ≠ 0; MOVZ writes when `reg2` = 0.
- **Invalid instruction:** loaded as a NOP with `inst_invalid_o` = 1, `wreg_o` = 0, `aluop`/`alusel` = NOP.
- **Handshake signals:**
  - slot_free = !`out_valid_o` | `out_ready_i`.
  - `in_ready_o` = slot_free & !hazard & !`flush_i`.
  - accept = `in_valid_i` & `in_ready_o`.
- **Slot update each clock, in priority order:**
  1. `rst`: all outputs cleared.
  2. `flush_i`: `out_valid_o` ← 0.
  3. accept: slot loads the decoded fields and `out_valid_o` ← 1.
  4. slot_free without accept: `out_valid_o` ← 0. This is the bubble on a hazard or an empty input.
  5. otherwise: hold all slot outputs unchanged.

## Timing
- **Latency:** 1 cycle from accept to `out_valid_o`. Full throughput of one instruction per cycle when there is no hazard and `out_ready_i` = 1.
- **Combinational paths:** `reg*_addr_o`, `reg*_read_o` and `in_ready_o` are combinational from inputs in the same cycle. All other outputs are registered.
- **Reset values:**
  - `out_valid_o`, `wreg_o`, `inst_invalid_o` = 0;
  - `aluop_o` = `EXE_NOP_OP`, `alusel_o` = `EXE_RES_NOP`;
  - `wd_o` = 0, `reg1_o` = 0, `reg2_o` = 0, `pc_o` = 0.
- **Reset mid-stall:** next cycle the slot is empty. No instruction is retained.
- **Backpressure:** while `out_valid_o` & !`out_ready_i`, every slot output is stable and `in_ready_o` = 0.
- **Flush with accept request in the same cycle:** flush wins. The instruction is not accepted (`in_ready_o` = 0) and `out_valid_o` = 0 next cycle.
- **Stall release:** a stall lasts exactly as long as the pending match persists. Accept occurs in the first cycle `fwd_pend_i` clears, and that cycle uses the forwarded data.

## Test plan
1. **ORI:** `inst` = 0x34011234, no forwarding → next cycle `out_valid_o` = 1, `aluop` = OR, `reg1_o` = 0 (regfile data for r0), `reg2_o` = 0x00001234, `wd_o` = 1, `wreg_o` = 1.
2. **Forwarding priority:** ADD r3,r1,r2 (0x00221820). Ch0 wd = 1 data = 5; ch1 wd = 1 data = 7 and wd = 2 data = 9 via the regfile path; `reg2_data_i` = 9 → `reg1_o` = 5, `reg2_o` = 9. Repeat with ch0 wd = 0 data = 5 → `reg1_o` = ch1 data 7, not 5.
3. **Load-use stall:** ch0 wd = 2, pend = 1 for 2 cycles with the ADD above → `in_ready_o` = 0 and `out_valid_o` = 0 for 2 cycles. Accept on cycle 3 with `reg2_o` = ch0 data.
4. **Backpressure:** `out_ready_i` = 0 for 3 cycles with ORI in the slot → outputs unchanged and `in_ready_o` = 0. `out_ready_i` = 1 → the next instruction loads.
5. **MOVZ with forwarded rt:** MOVZ r4,r1,r2 with ch0 forwarding r2 = 0 → `wreg_o` = 1. With r2 = 3 → `wreg_o` = 0.
6. **Flush / reset / invalid:** flush asserted with `in_valid_i` = 1 → `out_valid_o` = 0 next cycle and the instruction is not consumed. `rst` during a stall → all outputs at reset values. `inst` = 0xFC000000 → `inst_invalid_o` = 1, `wreg_o` = 0.
